fetcher: RTL and testbench

Instruction fetch unit: the consumer end of the PC/fetch interface. It takes the current fetch address from the PC block, issues one word request at a time to the instruction memory port, and buffers returned instructions with their PCs in a small FIFO for the decoder. After each accepted instruction it pulses `fetch2pc_enable` so the PC advances by 4. A ROB redirect flushes the FIFO and any in-flight request.

---
 rtl/fetcher_pkg.sv | 20 ++
 rtl/fetcher_if.sv | 30 +++
 rtl/fetch_queue.sv | 65 ++++++
 rtl/fetcher.sv | 91 +++++++++
 tb/tb_fetcher.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetcher_pkg.sv
// Shared widths, constants and types for the instruction fetch unit.
package fetcher_pkg;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        FetchIdle = 2'd0,
        FetchReq  = 2'd1,
        FetchStep = 2'd2,
        FetchDrop = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetcher_if.sv
// Bundle of the PC, ROB, instruction-memory and decoder signals seen by the fetcher.
interface fetcher_if;
    import fetcher_pkg::*;

    logic [ADDR_WIDTH-1:0] pc2fetch_next_pc;
    logic                  fetch2pc_enable;
    logic                  rob2fetch_flush;
    logic                  fetch2mem_req;
    logic [ADDR_WIDTH-1:0] fetch2mem_addr;
    logic                  mem2fetch_valid;
    logic [DATA_WIDTH-1:0] mem2fetch_inst;
    logic                  fetch2dec_valid;
    logic [DATA_WIDTH-1:0] fetch2dec_inst;
    logic [ADDR_WIDTH-1:0] fetch2dec_pc;
    logic                  dec2fetch_ready;

    modport master (
        input  pc2fetch_next_pc, rob2fetch_flush, mem2fetch_valid, mem2fetch_inst,
               dec2fetch_ready,
        output fetch2pc_enable, fetch2mem_req, fetch2mem_addr, fetch2dec_valid,
               fetch2dec_inst, fetch2dec_pc
    );

    modport slave (
        output pc2fetch_next_pc, rob2fetch_flush, mem2fetch_valid, mem2fetch_inst,
               dec2fetch_ready,
        input  fetch2pc_enable, fetch2mem_req, fetch2mem_addr, fetch2dec_valid,
               fetch2dec_inst, fetch2dec_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, inst} entries with push, pop and a clear that overrides both.
module fetch_queue
    import fetcher_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  fetch_entry_t            push_data_i,
    input  logic                    pop_i,
    output logic                    valid_o,
    output fetch_entry_t            head_o,
    output logic [$clog2(Depth):0]  count_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    fetch_entry_t    entries_q [Depth];
    logic            do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign head_o  = entries_q[rd_ptr_q];
    assign count_o = count_q;
    assign do_push = push_i && !clear_i;
    assign do_pop  = pop_i && valid_o && !clear_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            entries_q <= '{default: '0};
        end else if (rdy_in) begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) entries_q[wr_ptr_q] <= push_data_i;
        end
    end
endmodule

// File: rtl/fetcher.sv
// Instruction fetch unit: one outstanding memory request at a time, results queued for
// the decoder, PC stepped once per accepted instruction, ROB redirect flushes everything.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    fetcher_if.master  bus
);
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pc_en_q, pc_en_d;
    logic                  push, pop, q_valid;
    logic [CntW-1:0]       q_count;
    fetch_entry_t          q_head, push_data;

    assign push_data = '{pc: addr_q, inst: bus.mem2fetch_inst};
    assign pop       = q_valid && bus.dec2fetch_ready;

    fetch_queue #(
        .Depth(QUEUE_DEPTH)
    ) u_queue (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear_i     (bus.rob2fetch_flush),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (q_valid),
        .head_o      (q_head),
        .count_o     (q_count)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_en_d = pc_en_q;
        push    = FALSE;
        unique case (state_q)
            FetchIdle: begin
                if (!bus.rob2fetch_flush && (q_count < CntW'(QUEUE_DEPTH))) begin
                    addr_d  = bus.pc2fetch_next_pc;
                    state_d = FetchReq;
                end
            end
            FetchReq: begin
                // A flushed request must still be waited out: memory cannot cancel it.
                if (bus.rob2fetch_flush) begin
                    state_d = bus.mem2fetch_valid ? FetchIdle : FetchDrop;
                end else if (bus.mem2fetch_valid) begin
                    push    = TRUE;
                    pc_en_d = TRUE;
                    state_d = FetchStep;
                end
            end
            FetchStep: begin
                pc_en_d = FALSE;
                state_d = FetchIdle;
            end
            FetchDrop: begin
                if (bus.mem2fetch_valid) state_d = FetchIdle;
            end
            default: state_d = FetchIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= FetchIdle;
            addr_q  <= ZERO_ADDR;
            pc_en_q <= FALSE;
        end else if (rdy_in) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_en_q <= pc_en_d;
        end
    end

    assign bus.fetch2mem_req   = (state_q == FetchReq) || (state_q == FetchDrop);
    assign bus.fetch2mem_addr  = addr_q;
    assign bus.fetch2pc_enable = pc_en_q;
    assign bus.fetch2dec_valid = q_valid;
    assign bus.fetch2dec_inst  = q_head.inst;
    assign bus.fetch2dec_pc    = q_head.pc;
endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: memory/PC environment model, expected-instruction queue,
// directed scenarios followed by a randomized run.
module tb_fetcher;
    import fetcher_pkg::*;

    localparam int unsigned Depth = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;

    fetcher_if bus ();

    fetcher #(
        .QUEUE_DEPTH(Depth)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.master)
    );

    initial forever #5 clk_in = ~clk_in;

    int          n_cmp = 0, n_fail = 0;
    int          cyc = 0, lat = 2, cnt = 0;
    int          n_req = 0, n_dec = 0, n_pushed = 0, n_en = 0;
    int          en_cyc[$];
    logic [31:0] req_log[$];
    logic [31:0] req_addr = '0, last_req_addr = '0, pc_model = '0, flush_target = '0;
    bit          busy = 0, tainted = 0, pend_en = 0, pc_en_prev = 0;
    exp_t        exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory with fixed latency: strobe arrives lat cycles after the request is first seen.
    initial begin
        bus.mem2fetch_valid  = 1'b0;
        bus.mem2fetch_inst   = '0;
        bus.pc2fetch_next_pc = '0;
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            bus.pc2fetch_next_pc = pc_model;
            bus.mem2fetch_valid  = 1'b0;
            if (!rst_in) begin
                busy = 0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mem2fetch_valid = 1'b1;
                    bus.mem2fetch_inst  = mem_word(req_addr);
                    busy = 0;
                end
            end else if (bus.fetch2mem_req) begin
                busy          = 1;
                cnt           = lat;
                req_addr      = bus.fetch2mem_addr;
                last_req_addr = req_addr;
                req_log.push_back(req_addr);
                n_req++;
                chk("req_addr_vs_pc", req_addr, pc_model);
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    initial begin
        exp_t e;
        bit   fl, new_en;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                exp_q.delete();
                pend_en = 0; tainted = 0; pc_model = '0; pc_en_prev = 0;
            end else begin
                chk("dec_valid", bus.fetch2dec_valid, exp_q.size() != 0);
                if (bus.fetch2dec_valid && bus.dec2fetch_ready && rdy_in && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("dec_pc", bus.fetch2dec_pc, e.pc);
                    chk("dec_inst", bus.fetch2dec_inst, e.inst);
                    n_dec++;
                end
                chk("pc_enable", bus.fetch2pc_enable, pend_en);
                if (bus.fetch2pc_enable && !pc_en_prev) begin
                    en_cyc.push_back(cyc);
                    n_en++;
                end
                pc_en_prev = bus.fetch2pc_enable;
                if (busy) begin
                    chk("req_held", bus.fetch2mem_req, 1'b1);
                    chk("addr_stable", bus.fetch2mem_addr, req_addr);
                end
                if (exp_q.size() == Depth && !busy) chk("full_no_req", bus.fetch2mem_req, 1'b0);
                if (rdy_in) begin
                    fl     = bus.rob2fetch_flush;
                    new_en = 0;
                    if (fl) begin
                        exp_q.delete();
                        if (busy) tainted = 1;
                    end
                    if (bus.mem2fetch_valid) begin
                        if (!fl && !tainted) begin
                            exp_q.push_back('{pc: req_addr, inst: bus.mem2fetch_inst});
                            new_en = 1;
                            n_pushed++;
                        end
                        tainted = 0;
                    end
                    if (fl) pc_model = flush_target;
                    else if (bus.fetch2pc_enable) pc_model = pc_model + 32'd4;
                    pend_en = new_en;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic do_reset(input int l, input logic dec_rdy);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        bus.rob2fetch_flush = 1'b0;
        bus.dec2fetch_ready = dec_rdy;
        lat = l;
        flush_target = '0;
        repeat (2) step();
        req_log.delete(); en_cyc.delete();
        n_req = 0; n_dec = 0; n_pushed = 0; n_en = 0;
        chk("rst_req", bus.fetch2mem_req, 1'b0);
        chk("rst_pc_en", bus.fetch2pc_enable, 1'b0);
        chk("rst_addr", bus.fetch2mem_addr, 32'h0);
        chk("rst_dec_valid", bus.fetch2dec_valid, 1'b0);
        chk("rst_dec_inst", bus.fetch2dec_inst, 32'h0);
        chk("rst_dec_pc", bus.fetch2dec_pc, 32'h0);
        rst_in = 1'b1;
    endtask

    initial begin
        int t, snap;
        logic [31:0] prior;
        bus.rob2fetch_flush = 1'b0;
        bus.dec2fetch_ready = 1'b1;

        // Reset and two back-to-back fetches with latency 2.
        do_reset(2, 1'b1);
        t = 0;
        while (n_dec < 2 && t < 100) begin step(); t++; end
        chk("p1_done", t < 100, 1'b1);
        if (req_log.size() >= 2) begin
            chk("p1_addr0", req_log[0], 32'h0);
            chk("p1_addr1", req_log[1], 32'h4);
        end else chk("p1_req_count", req_log.size(), 2);
        if (en_cyc.size() >= 2) chk("p1_en_spacing", en_cyc[1] - en_cyc[0], 5);
        else chk("p1_en_count", en_cyc.size(), 2);

        // FIFO fills with the decoder stalled, then one pop frees a slot.
        do_reset(2, 1'b0);
        repeat (60) step();
        chk("p2_en_count", n_en, 4);
        chk("p2_req_count", n_req, 4);
        bus.dec2fetch_ready = 1'b1;
        step();
        bus.dec2fetch_ready = 1'b0;
        t = 0;
        while (n_req < 5 && t < 20) begin step(); t++; end
        chk("p2_resume", t < 20, 1'b1);
        chk("p2_addr16", last_req_addr, 32'd16);

        // Flush during a long-latency request; late response must be dropped.
        do_reset(5, 1'b0);
        t = 0;
        while (!(busy && req_addr == 32'h8) && t < 100) begin step(); t++; end
        chk("p3_reach_addr8", t < 100, 1'b1);
        flush_target = 32'h100;
        bus.rob2fetch_flush = 1'b1;
        step();
        bus.rob2fetch_flush = 1'b0;
        t = 0;
        while (n_req < 4 && t < 50) begin step(); t++; end
        chk("p3_redirect_req", t < 50, 1'b1);
        chk("p3_addr_redirect", last_req_addr, 32'h100);
        chk("p3_en_count", n_en, 2);

        // Flush coinciding with a memory response and a decoder pop.
        do_reset(3, 1'b0);
        t = 0;
        while (!(n_pushed >= 1 && bus.mem2fetch_valid) && t < 100) begin step(); t++; end
        chk("p4_reach_resp", t < 100, 1'b1);
        flush_target = 32'h200;
        bus.rob2fetch_flush = 1'b1;
        bus.dec2fetch_ready = 1'b1;
        step();
        chk("p4_dec_valid_cleared", bus.fetch2dec_valid, 1'b0);
        chk("p4_no_pc_en", bus.fetch2pc_enable, 1'b0);
        chk("p4_en_count", n_en, 1);
        bus.rob2fetch_flush = 1'b0;
        bus.dec2fetch_ready = 1'b0;
        t = 0;
        while (n_req < 3 && t < 50) begin step(); t++; end
        chk("p4_addr_redirect", last_req_addr, 32'h200);

        // Global stall while fetch2pc_enable is pending.
        do_reset(2, 1'b1);
        t = 0;
        while (!bus.fetch2pc_enable && t < 50) begin step(); t++; end
        chk("p5_reach_step", t < 50, 1'b1);
        prior  = last_req_addr;
        snap   = n_req;
        rdy_in = 1'b0;
        repeat (3) begin
            step();
            chk("p5_en_held", bus.fetch2pc_enable, 1'b1);
        end
        rdy_in = 1'b1;
        t = 0;
        while (n_req == snap && t < 50) begin step(); t++; end
        chk("p5_next_addr", last_req_addr, prior + 32'd4);

        // Asynchronous reset in the middle of a request.
        do_reset(4, 1'b1);
        t = 0;
        while (!busy && t < 50) begin step(); t++; end
        chk("p6_reach_req", t < 50, 1'b1);
        #1 rst_in = 1'b0;
        #1;
        chk("p6_req", bus.fetch2mem_req, 1'b0);
        chk("p6_pc_en", bus.fetch2pc_enable, 1'b0);
        chk("p6_addr", bus.fetch2mem_addr, 32'h0);
        chk("p6_dec_valid", bus.fetch2dec_valid, 1'b0);
        chk("p6_dec_pc", bus.fetch2dec_pc, 32'h0);
        chk("p6_dec_inst", bus.fetch2dec_inst, 32'h0);
        repeat (2) step();
        snap   = n_req;
        rst_in = 1'b1;
        t = 0;
        while (n_req == snap && t < 50) begin step(); t++; end
        chk("p6_restart_addr", last_req_addr, 32'h0);

        // Randomized traffic: latency, decoder backpressure, stalls and redirects.
        do_reset(2, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            if (!busy && $urandom_range(0, 3) == 0) lat = $urandom_range(1, 4);
            bus.dec2fetch_ready = ($urandom_range(0, 2) != 0);
            rdy_in = (!busy && !bus.mem2fetch_valid && $urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            if (rdy_in && $urandom_range(0, 24) == 0) begin
                flush_target = $urandom & 32'h0000_fffc;
                bus.rob2fetch_flush = 1'b1;
            end else begin
                bus.rob2fetch_flush = 1'b0;
            end
            step();
        end
        bus.rob2fetch_flush = 1'b0;
        bus.dec2fetch_ready = 1'b1;
        rdy_in = 1'b1;
        repeat (40) step();
        chk("rand_progress", n_dec > 50, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
